// File: rtl/snoop_cache_ctrl_gen.sv
// snoop_cache_ctrl_gen: ACE snoop controller for the std data cache.
// Optional SNOOP_CTRL_CRIT_WORD_FIRST_EN: CD starts at the critical beat.
module snoop_cache_ctrl_gen #(
  parameter int unsigned SET_ASSOC = 8,
  parameter int unsigned INDEX_W   = 12,
  parameter int unsigned TAG_W     = 44,
  parameter int unsigned LINE_W    = 128,
  parameter int unsigned CD_W      = 64,
  parameter int unsigned ADDR_W    = 56
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          bypass_i,
  output logic                          busy_o,
  input  logic                          ac_valid_i,
  output logic                          ac_ready_o,
  input  logic [ADDR_W-1:0]             ac_addr_i,
  input  logic [3:0]                    ac_snoop_i,
  output logic                          cr_valid_o,
  input  logic                          cr_ready_i,
  output logic [4:0]                    cr_resp_o,
  output logic                          cd_valid_o,
  input  logic                          cd_ready_i,
  output logic [CD_W-1:0]               cd_data_o,
  output logic                          cd_last_o,
  output logic [SET_ASSOC-1:0]          req_o,
  output logic [INDEX_W-1:0]            addr_o,
  output logic [TAG_W-1:0]              tag_o,
  input  logic                          gnt_i,
  output logic                          we_o,
  output logic [SET_ASSOC-1:0]          be_vldrty_o,
  output logic                          wvalid_o,
  output logic                          wdirty_o,
  output logic                          wshared_o,
  input  logic [SET_ASSOC*LINE_W-1:0]   rdata_i,
  input  logic [SET_ASSOC-1:0]          hit_way_i,
  input  logic [SET_ASSOC-1:0]          dirty_way_i,
  input  logic [SET_ASSOC-1:0]          shared_way_i,
  output logic                          mh_req_o,
  output logic [ADDR_W-1:0]             mh_addr_o,
  input  logic                          mh_gnt_i
);

  localparam int unsigned BEATS  = LINE_W / CD_W;
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_LO = $clog2(CD_W / 8);

  localparam logic [3:0] RD_ONCE  = 4'b0000;
  localparam logic [3:0] RD_SHRD  = 4'b0001;
  localparam logic [3:0] RD_CLN   = 4'b0010;
  localparam logic [3:0] RD_NSD   = 4'b0011;
  localparam logic [3:0] RD_UNQ   = 4'b0111;
  localparam logic [3:0] CLN_SHRD = 4'b1000;
  localparam logic [3:0] CLN_INV  = 4'b1001;
  localparam logic [3:0] MK_INV   = 4'b1101;

  typedef enum logic [2:0] {
    IDLE, WAIT_GNT, EVAL, UPDATE, WAIT_MH, SEND_CR, SEND_CD
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          snoop_q, snoop_d;
  logic [4:0]          resp_q, resp_d;
  logic [SET_ASSOC-1:0] hit_way_q, hit_way_d;
  logic                dirty_q, dirty_d;
  logic                shared_q, shared_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BW-1:0]       beat_q, beat_d;

  logic [LINE_W-1:0]   hit_line;
  logic [BW-1:0]       start_beat;
  logic [BW-1:0]       nxt_beat;
  logic                wu;

  function automatic logic supported(input logic [3:0] c);
    case (c)
      RD_ONCE, RD_SHRD, RD_CLN, RD_NSD,
      RD_UNQ, CLN_SHRD, CLN_INV, MK_INV: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic invalidating(input logic [3:0] c);
    return (c == RD_UNQ) || (c == CLN_INV) || (c == MK_INV);
  endfunction

`ifdef SNOOP_CTRL_CRIT_WORD_FIRST_EN
  // first beat sent is the one holding the snooped word
  assign start_beat = BW'((addr_q >> OFF_LO) % ADDR_W'(BEATS));
`else
  assign start_beat = '0;
`endif

  assign nxt_beat = (beat_q == BW'(BEATS - 1)) ? '0 : beat_q + BW'(1);

  assign busy_o    = (state_q != IDLE);
  assign cr_resp_o = resp_q;
  assign tag_o     = addr_q[INDEX_W +: TAG_W];
  assign mh_addr_o = addr_q;
  assign addr_o    = addr_d[INDEX_W-1:0];

  // select the line of the hitting way
  always_comb begin
    hit_line = '0;
    for (int i = 0; i < SET_ASSOC; i++) begin
      if (hit_way_i[i]) hit_line = rdata_i[i*LINE_W +: LINE_W];
    end
  end

  // next-state and output decode
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    snoop_d     = snoop_q;
    resp_d      = resp_q;
    hit_way_d   = hit_way_q;
    dirty_d     = dirty_q;
    shared_d    = shared_q;
    line_d      = line_q;
    beat_d      = beat_q;
    wu          = 1'b0;
    ac_ready_o  = 1'b0;
    cr_valid_o  = 1'b0;
    cd_valid_o  = 1'b0;
    cd_data_o   = '0;
    cd_last_o   = 1'b0;
    req_o       = '0;
    we_o        = 1'b0;
    be_vldrty_o = '0;
    wvalid_o    = 1'b0;
    wdirty_o    = 1'b0;
    wshared_o   = 1'b0;
    mh_req_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) begin
          addr_d  = ac_addr_i;
          snoop_d = ac_snoop_i;
          resp_d  = '0;
          if (bypass_i) begin
            state_d = SEND_CR;
          end else if (!supported(ac_snoop_i)) begin
            resp_d[1] = 1'b1;
            state_d   = SEND_CR;
          end else begin
            req_o   = '1;
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req_o = '1;
        if (gnt_i) state_d = EVAL;
      end
      EVAL: begin
        hit_way_d = hit_way_i;
        dirty_d   = |(hit_way_i & dirty_way_i);
        shared_d  = |(hit_way_i & shared_way_i);
        line_d    = hit_line;
        wu        = ~shared_d;
        if (hit_way_i == '0) begin
          resp_d  = '0;
          state_d = SEND_CR;
        end else begin
          state_d = UPDATE;
          case (snoop_q)
            RD_ONCE: begin
              resp_d  = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
              state_d = SEND_CR;
            end
            RD_SHRD, RD_CLN, RD_NSD:
              resp_d = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
            CLN_SHRD:
              resp_d = {wu, 1'b1, dirty_d, 1'b0, dirty_d};
            RD_UNQ:
              resp_d = {wu, 1'b0, dirty_d, 1'b0, 1'b1};
            CLN_INV:
              resp_d = {wu, 1'b0, dirty_d, 1'b0, dirty_d};
            MK_INV:
              resp_d = {wu, 1'b0, 1'b0, 1'b0, 1'b0};
            default: begin
              resp_d  = 5'b00010;
              state_d = SEND_CR;
            end
          endcase
        end
      end
      UPDATE: begin
        req_o       = hit_way_q;
        be_vldrty_o = hit_way_q;
        we_o        = 1'b1;
        if (snoop_q == CLN_SHRD) begin
          wvalid_o  = 1'b1;
          wdirty_o  = 1'b0;
          wshared_o = shared_q;
        end else if (!invalidating(snoop_q)) begin
          wvalid_o  = 1'b1;
          wdirty_o  = dirty_q;
          wshared_o = 1'b1;
        end
        if (gnt_i) begin
          state_d = invalidating(snoop_q) ? WAIT_MH : SEND_CR;
        end
      end
      WAIT_MH: begin
        mh_req_o = 1'b1;
        if (mh_gnt_i) state_d = SEND_CR;
      end
      SEND_CR: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          if (resp_q[0]) begin
            beat_d  = start_beat;
            state_d = SEND_CD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SEND_CD: begin
        cd_valid_o = 1'b1;
        cd_data_o  = line_q[int'(beat_q)*CD_W +: CD_W];
        cd_last_o  = (nxt_beat == start_beat);
        if (cd_ready_i) begin
          beat_d = nxt_beat;
          if (cd_last_o) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and transaction registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      resp_q    <= '0;
      hit_way_q <= '0;
      dirty_q   <= 1'b0;
      shared_q  <= 1'b0;
      line_q    <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      snoop_q   <= snoop_d;
      resp_q    <= resp_d;
      hit_way_q <= hit_way_d;
      dirty_q   <= dirty_d;
      shared_q  <= shared_d;
      line_q    <= line_d;
      beat_q    <= beat_d;
    end
  end

endmodule

// File: tb/tb_snoop_cache_ctrl_gen.sv
// tb_snoop_cache_ctrl_gen: scoreboard bench for the snoop controller.
// Expected CR/CD/SRAM-write/miss-handler traffic is queued per snoop.
module tb_snoop_cache_ctrl_gen;

  localparam int SA = 8;
  localparam int IW = 12;
  localparam int TW = 44;
  localparam int CW = 64;
  localparam int AW = 56;
`ifdef SNOOP_CTRL_CRIT_WORD_FIRST_EN
  localparam int LW = 256;
`else
  localparam int LW = 128;
`endif
  localparam int BEATS = LW / CW;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic bypass_i;
  logic busy_o;
  logic ac_valid_i;
  logic ac_ready_o;
  logic [AW-1:0] ac_addr_i;
  logic [3:0] ac_snoop_i;
  logic cr_valid_o;
  logic cr_ready_i;
  logic [4:0] cr_resp_o;
  logic cd_valid_o;
  logic cd_ready_i;
  logic [CW-1:0] cd_data_o;
  logic cd_last_o;
  logic [SA-1:0] req_o;
  logic [IW-1:0] addr_o;
  logic [TW-1:0] tag_o;
  logic gnt_i;
  logic we_o;
  logic [SA-1:0] be_vldrty_o;
  logic wvalid_o, wdirty_o, wshared_o;
  logic [SA*LW-1:0] rdata_i;
  logic [SA-1:0] hit_way_i, dirty_way_i, shared_way_i;
  logic mh_req_o;
  logic [AW-1:0] mh_addr_o;
  logic mh_gnt_i;

  snoop_cache_ctrl_gen #(
    .SET_ASSOC(SA), .INDEX_W(IW), .TAG_W(TW),
    .LINE_W(LW), .CD_W(CW), .ADDR_W(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .bypass_i(bypass_i),
    .busy_o(busy_o),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
    .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i),
    .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
    .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .req_o(req_o), .addr_o(addr_o), .tag_o(tag_o),
    .gnt_i(gnt_i), .we_o(we_o), .be_vldrty_o(be_vldrty_o),
    .wvalid_o(wvalid_o), .wdirty_o(wdirty_o),
    .wshared_o(wshared_o), .rdata_i(rdata_i),
    .hit_way_i(hit_way_i), .dirty_way_i(dirty_way_i),
    .shared_way_i(shared_way_i),
    .mh_req_o(mh_req_o), .mh_addr_o(mh_addr_o),
    .mh_gnt_i(mh_gnt_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [4:0]    cr_q[$];
  logic [CW:0]   cd_q[$];
  logic [2*SA+2:0] wr_q[$];
  logic [AW-1:0] mh_q[$];

  int cr_stall_cfg = 0;
  int cd_stall_cfg = 0;
  int cr_st, cd_st, mh_cnt;
  int lk_cnt = 0;
  int cr_vcyc = 0;
  logic [IW-1:0] cur_idx;
  logic [TW-1:0] cur_tag;

  function automatic logic [CW-1:0] pat(int tx, int w, int b);
    return {16'(tx), 16'hC0DE, 16'(w), 16'(b)};
  endfunction

  // SRAM, miss-handler and CR/CD sink with scoreboard compare
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      gnt_i = 1'b0;
      mh_gnt_i = 1'b0;
      mh_cnt = 0;
      cr_ready_i = 1'b1;
      cd_ready_i = 1'b1;
      cr_st = 0;
      cd_st = 0;
    end else begin
      gnt_i = (req_o != '0);
      if (req_o != '0 && !we_o) begin
        lk_cnt++;
        check("sram_idx", addr_o, cur_idx);
        if (!ac_ready_o) check("sram_tag", tag_o, cur_tag);
      end
      if (we_o && gnt_i) begin
        if (wr_q.size() != 0)
          check("sram_wr",
                {req_o, be_vldrty_o, wvalid_o, wdirty_o, wshared_o},
                wr_q.pop_front());
        else
          check("wr_unexp", we_o, 1'b0);
      end
      if (mh_req_o) begin
        mh_cnt++;
        mh_gnt_i = (mh_cnt >= 3);
        if (mh_q.size() != 0) begin
          check("mh_addr", mh_addr_o, mh_q[0]);
          if (mh_gnt_i) void'(mh_q.pop_front());
        end else begin
          check("mh_unexp", mh_req_o, 1'b0);
        end
      end else begin
        mh_cnt = 0;
        mh_gnt_i = 1'b0;
      end
      if (cr_valid_o) begin
        cr_vcyc++;
        cr_ready_i = (cr_st >= cr_stall_cfg);
        if (!cr_ready_i) cr_st++;
        if (cr_q.size() != 0) begin
          if (cr_ready_i)
            check("cr_resp", cr_resp_o, cr_q.pop_front());
          else
            check("cr_hold", cr_resp_o, cr_q[0]);
        end else begin
          check("cr_unexp", cr_valid_o, 1'b0);
        end
      end else begin
        cr_st = 0;
        cr_ready_i = 1'b1;
      end
      if (cd_valid_o) begin
        cd_ready_i = (cd_st >= cd_stall_cfg);
        if (!cd_ready_i) cd_st++;
        if (cd_q.size() != 0) begin
          if (cd_ready_i)
            check("cd_beat", {cd_last_o, cd_data_o},
                  cd_q.pop_front());
          else
            check("cd_hold", {cd_last_o, cd_data_o}, cd_q[0]);
        end else begin
          check("cd_unexp", cd_valid_o, 1'b0);
        end
      end else begin
        cd_st = 0;
        cd_ready_i = 1'b1;
      end
    end
  end

  int tx = 0;

  // load lookup inputs and push the expected traffic of one snoop
  task automatic setup(input logic [AW-1:0] a, input logic [3:0] code,
                       input int way, input logic hit,
                       input logic dty, input logic shr,
                       input logic byp, output logic lookup);
    logic [SA-1:0] oh;
    logic [4:0] r;
    logic [2:0] wb;
    logic upd, inv, supp, wu;
    int st;
    tx++;
    oh = SA'(1) << way;
    for (int w = 0; w < SA; w++)
      for (int b = 0; b < BEATS; b++)
        rdata_i[w*LW + b*CW +: CW] = pat(tx, w, b);
    hit_way_i = hit ? oh : '0;
    dirty_way_i = dty ? oh : ~oh;
    shared_way_i = shr ? oh : ~oh;
    bypass_i = byp;
    cur_idx = a[IW-1:0];
    cur_tag = a[IW +: TW];
    supp = (code inside {4'h0, 4'h1, 4'h2, 4'h3,
                         4'h7, 4'h8, 4'h9, 4'hD});
    inv = (code inside {4'h7, 4'h9, 4'hD});
    wu = ~shr;
    r = '0;
    wb = '0;
    upd = 1'b0;
    lookup = !byp && supp;
    if (byp) r = '0;
    else if (!supp) r = 5'b00010;
    else if (hit) begin
      upd = (code != 4'h0);
      case (code)
        4'h0, 4'h1, 4'h2, 4'h3: begin
          r = {wu, 1'b1, 1'b0, 1'b0, 1'b1};
          wb = {1'b1, dty, 1'b1};
        end
        4'h8: begin
          r = {wu, 1'b1, dty, 1'b0, dty};
          wb = {1'b1, 1'b0, shr};
        end
        4'h7: r = {wu, 1'b0, dty, 1'b0, 1'b1};
        4'h9: r = {wu, 1'b0, dty, 1'b0, dty};
        default: r = {wu, 4'b0000};
      endcase
    end
    cr_q.push_back(r);
    if (upd) wr_q.push_back({oh, oh, wb});
    if (upd && inv) mh_q.push_back(a);
    if (r[0]) begin
`ifdef SNOOP_CTRL_CRIT_WORD_FIRST_EN
      st = int'(a[4:3]) % BEATS;
`else
      st = 0;
`endif
      for (int k = 0; k < BEATS; k++)
        cd_q.push_back({k == BEATS - 1,
                        pat(tx, way, (st + k) % BEATS)});
    end
    ac_addr_i = a;
    ac_snoop_i = code;
  endtask

  task automatic snoop(input string nm,
                       input logic [AW-1:0] a, input logic [3:0] code,
                       input int way, input logic hit,
                       input logic dty, input logic shr,
                       input logic byp, input int crs, input int cds);
    logic lookup;
    int lk0, cv0;
    @(posedge clk_i); #1;
    cr_stall_cfg = crs;
    cd_stall_cfg = cds;
    lk0 = lk_cnt;
    cv0 = cr_vcyc;
    setup(a, code, way, hit, dty, shr, byp, lookup);
    check({nm, "_acrdy"}, ac_ready_o, 1'b1);
    ac_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ac_valid_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_o) break;
      @(posedge clk_i); #1;
    end
    check({nm, "_done"}, busy_o, 1'b0);
    check({nm, "_lookup"}, lk_cnt != lk0, lookup);
    check({nm, "_crcyc"}, cr_vcyc - cv0, crs + 1);
    check({nm, "_drain"},
          cr_q.size() + cd_q.size() + wr_q.size() + mh_q.size(), 0);
    cr_q.delete(); cd_q.delete(); wr_q.delete(); mh_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lk;
    rst_ni = 1'b0;
    ac_valid_i = 1'b0;
    bypass_i = 1'b0;
    ac_addr_i = '0;
    ac_snoop_i = '0;
    rdata_i = '0;
    hit_way_i = '0;
    dirty_way_i = '0;
    shared_way_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_acrdy", ac_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_crv", cr_valid_o, 1'b0);
    check("rst_cdv", cd_valid_o, 1'b0);
    check("rst_req", {req_o, we_o, mh_req_o}, '0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    snoop("t1_rdshrd", 56'h12_3456_789A_BC40, 4'h1, 2, 1, 0, 0, 0, 0, 0);
    snoop("t2_rdunq", 56'hAB_CDEF_0123_4580, 4'h7, 5, 1, 1, 0, 0, 0, 0);
    snoop("t3_clnshr_c", 56'h00_1111_2222_3300, 4'h8, 1, 1, 0, 1, 0, 0, 0);
    snoop("t3_clnshr_d", 56'h00_1111_2222_3340, 4'h8, 0, 1, 1, 0, 0, 0, 0);
    snoop("t4_unsup", 56'h00_0000_0000_1000, 4'hE, 3, 1, 1, 0, 0, 0, 0);
    snoop("t4_bypass", 56'h00_0000_0000_2000, 4'h0, 3, 1, 1, 0, 1, 0, 0);
    snoop("rdonce", 56'h77_0000_0000_0010, 4'h0, 7, 1, 1, 1, 0, 0, 0);
    snoop("rdclean", 56'h66_0000_0000_0FC0, 4'h2, 4, 1, 0, 1, 0, 0, 0);
    snoop("rdnsd", 56'h55_0000_0000_0A80, 4'h3, 6, 1, 1, 0, 0, 0, 0);
    snoop("clninv_d", 56'h44_0000_0000_0200, 4'h9, 3, 1, 1, 1, 0, 0, 0);
    snoop("clninv_c", 56'h43_0000_0000_0240, 4'h9, 2, 1, 0, 0, 0, 0, 0);
    snoop("mkinv", 56'h33_0000_0000_0500, 4'hD, 1, 1, 1, 0, 0, 0, 0);
    snoop("miss", 56'h22_0000_0000_0600, 4'h1, 0, 0, 0, 0, 0, 0, 0);
    snoop("t5_stall", 56'h11_0000_0000_0700, 4'h7, 6, 1, 0, 0, 0, 5, 4);
    snoop("t6_cwf", 56'h0F_0000_0000_0810, 4'h1, 2, 1, 0, 0, 0, 0, 0);

    // asynchronous reset while the CR is stalled
    @(posedge clk_i); #1;
    cr_stall_cfg = 50;
    setup(56'h99_0000_0000_0900, 4'h1, 4, 1, 0, 0, 0, lk);
    ac_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ac_valid_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cr_valid_o) break;
      @(posedge clk_i); #1;
    end
    check("abort_crv", cr_valid_o, 1'b1);
    #1;
    rst_ni = 1'b0;
    cr_q.delete(); cd_q.delete(); wr_q.delete(); mh_q.delete();
    cr_stall_cfg = 0;
    #1;
    check("abort_busy", busy_o, 1'b0);
    check("abort_crv0", cr_valid_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    check("abort_idle", {ac_ready_o, busy_o, cd_valid_o}, 3'b100);

    snoop("post_rst", 56'h98_0000_0000_0940, 4'h1, 3, 1, 1, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
